// File: rtl/note_parser.sv
// Character-stream to note-index parser: assembles octave/letter/symbol ROM
// addresses into a 6-bit note. Optional error counter under NOTE_PARSER_ERRCNT_EN.
module note_parser #(
  parameter int TIMEOUT  = 0,
  parameter int MAX_NOTE = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] char_addr,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [5:0] note,
  output logic       note_valid,
  input  logic       note_ready,
  output logic       err
`ifdef NOTE_PARSER_ERRCNT_EN
  ,
  input  logic       err_clear,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    S_NUM,
    S_LET,
    S_SYM,
    S_OUT
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t     state_q, state_d;
  logic [2:0] oct_q, oct_d;        // octave 1..6, 0 marks a rest token
  logic [2:0] let_q, let_d;        // letter A..G as 1..7
  logic [5:0] note_q, note_d;
  logic       note_valid_q, note_valid_d;
  logic       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       is_space, is_hash, is_digit, is_letter;
  logic       hash_ok, in_range, timeout_hit;
  logic [3:0] let_off;
  logic [6:0] oct_base, note_calc;

  assign char_ready = (state_q != S_OUT);
  assign accept     = char_valid && char_ready;

  assign is_space  = (char_addr == 9'h100);
  assign is_hash   = (char_addr == 9'h118);
  assign is_digit  = (char_addr[8:6] == 3'b110) && (char_addr[2:0] == 3'd0) &&
                     (char_addr[5:3] != 3'd0) && (char_addr[5:3] != 3'd7);
  assign is_letter = (char_addr[8:6] == 3'b000) && (char_addr[2:0] == 3'd0) &&
                     (char_addr[5:3] != 3'd0);

  always_comb begin
    case (let_q)
      3'd1:    let_off = 4'd0;
      3'd2:    let_off = 4'd2;
      3'd3:    let_off = 4'd3;
      3'd4:    let_off = 4'd5;
      3'd5:    let_off = 4'd7;
      3'd6:    let_off = 4'd8;
      3'd7:    let_off = 4'd10;
      default: let_off = 4'd0;
    endcase
  end

  // B and E have no sharp; the sum is kept 7 bits wide so overflow past 63 is visible.
  assign hash_ok   = (let_q != 3'd2) && (let_q != 3'd5);
  assign oct_base  = 7'd12 * (7'(oct_q) - 7'd1);
  assign note_calc = oct_base + 7'(let_off) + 7'(is_hash) + 7'd1;
  assign in_range  = !note_calc[6] && (int'(note_calc) <= MAX_NOTE);

  // Idle cycles inside a partial token; never counts in S_NUM or S_OUT.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if ((TIMEOUT > 0) && ((state_q == S_LET) || (state_q == S_SYM)) && !accept) begin
      if (int'(cnt_q) == TIMEOUT - 1) begin
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    oct_d        = oct_q;
    let_d        = let_q;
    note_d       = note_q;
    note_valid_d = note_valid_q;
    err_d        = 1'b0;

    case (state_q)
      S_NUM: begin
        if (accept) begin
          if (is_digit) begin
            oct_d   = char_addr[5:3];
            let_d   = 3'd0;
            state_d = S_LET;
          end else if (is_space) begin
            oct_d   = 3'd0;
            let_d   = 3'd0;
            state_d = S_LET;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LET: begin
        if (accept) begin
          if ((oct_q != 3'd0) && is_letter) begin
            let_d   = char_addr[5:3];
            state_d = S_SYM;
          end else if ((oct_q == 3'd0) && is_space) begin
            state_d = S_SYM;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end

      S_SYM: begin
        if (accept) begin
          if (oct_q == 3'd0) begin
            if (is_space) begin
              note_d       = 6'd0;
              note_valid_d = 1'b1;
              state_d      = S_OUT;
            end else begin
              err_d = 1'b1;
            end
          end else if ((is_space || (is_hash && hash_ok)) && in_range) begin
            note_d       = note_calc[5:0];
            note_valid_d = 1'b1;
            state_d      = S_OUT;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end

      S_OUT: begin
        if (note_ready) begin
          note_valid_d = 1'b0;
          state_d      = S_NUM;
        end
      end

      default: state_d = S_NUM;
    endcase

    if (err_d) begin
      state_d = S_NUM;
      oct_d   = 3'd0;
      let_d   = 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_NUM;
      oct_q        <= 3'd0;
      let_q        <= 3'd0;
      note_q       <= 6'd0;
      note_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      oct_q        <= oct_d;
      let_q        <= let_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign err        = err_q;

`ifdef NOTE_PARSER_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (err_clear) begin
      err_count_q <= 8'd0;
    end else if (err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_note_parser.sv
// Directed bench for note_parser: table of tokens plus hand sequences for
// back-pressure, timeout and asynchronous reset.
module tb_note_parser;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] char_addr;
  logic       char_valid;
  logic       char_ready;
  logic [5:0] note;
  logic       note_valid;
  logic       note_ready;
  logic       err;
`ifdef NOTE_PARSER_ERRCNT_EN
  logic       err_clear;
  logic [7:0] err_count;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  note_parser #(.TIMEOUT(TO), .MAX_NOTE(63)) dut (
    .clk       (clk),
    .reset     (reset),
    .char_addr (char_addr),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .note      (note),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .err       (err)
`ifdef NOTE_PARSER_ERRCNT_EN
    ,
    .err_clear (err_clear),
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [8:0] c0;
    logic [8:0] c1;
    logic [8:0] c2;
    int         n;
    logic       exp_err;
    logic [5:0] exp_note;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put_char(input logic [8:0] a, input string tag);
    @(negedge clk);
    char_valid = 1'b1;
    char_addr  = a;
    check({tag, " char_ready"}, 9'(char_ready), 9'd1);
    check({tag, " err before char"}, 9'(err), 9'd0);
  endtask

  task automatic finish_token(input logic e, input logic [5:0] nt, input string tag);
    @(negedge clk);
    char_valid = 1'b0;
    check({tag, " err"}, 9'(err), 9'(e));
    check({tag, " note_valid"}, 9'(note_valid), 9'(!e));
    if (!e) check({tag, " note"}, 9'(note), 9'(nt));
    if (e) n_errs++;
    @(negedge clk);
    check({tag, " err cleared"}, 9'(err), 9'd0);
    check({tag, " note_valid cleared"}, 9'(note_valid), 9'd0);
    check({tag, " char_ready after"}, 9'(char_ready), 9'd1);
  endtask

  task automatic run_token(input logic [8:0] c0, input logic [8:0] c1, input logic [8:0] c2,
                           input int n, input logic e, input logic [5:0] nt, input string tag);
    put_char(c0, tag);
    if (n > 1) put_char(c1, tag);
    if (n > 2) put_char(c2, tag);
    finish_token(e, nt, tag);
  endtask

  initial begin
    vecs[0]  = '{9'h188, 9'h008, 9'h100, 3, 1'b0, 6'd1};
    vecs[1]  = '{9'h1A8, 9'h038, 9'h118, 3, 1'b0, 6'd60};
    vecs[2]  = '{9'h1B0, 9'h010, 9'h100, 3, 1'b0, 6'd63};
    vecs[3]  = '{9'h1B0, 9'h018, 9'h100, 3, 1'b1, 6'd0};
    vecs[4]  = '{9'h100, 9'h100, 9'h100, 3, 1'b0, 6'd0};
    vecs[5]  = '{9'h100, 9'h008, 9'h000, 2, 1'b1, 6'd0};
    vecs[6]  = '{9'h190, 9'h010, 9'h118, 3, 1'b1, 6'd0};
    vecs[7]  = '{9'h198, 9'h018, 9'h118, 3, 1'b0, 6'd29};
    vecs[8]  = '{9'h188, 9'h020, 9'h118, 3, 1'b0, 6'd7};
    vecs[9]  = '{9'h1A0, 9'h030, 9'h100, 3, 1'b0, 6'd45};
    vecs[10] = '{9'h188, 9'h028, 9'h118, 3, 1'b1, 6'd0};
    vecs[11] = '{9'h1B8, 9'h000, 9'h000, 1, 1'b1, 6'd0};
    vecs[12] = '{9'h180, 9'h000, 9'h000, 1, 1'b1, 6'd0};
    vecs[13] = '{9'h008, 9'h000, 9'h000, 1, 1'b1, 6'd0};
    vecs[14] = '{9'h188, 9'h100, 9'h000, 2, 1'b1, 6'd0};
    vecs[15] = '{9'h188, 9'h008, 9'h008, 3, 1'b1, 6'd0};
    vecs[16] = '{9'h100, 9'h100, 9'h118, 3, 1'b1, 6'd0};
    vecs[17] = '{9'h1B0, 9'h008, 9'h118, 3, 1'b0, 6'd62};
    vecs[18] = '{9'h1B0, 9'h038, 9'h118, 3, 1'b1, 6'd0};
    vecs[19] = '{9'h1A8, 9'h008, 9'h100, 3, 1'b0, 6'd49};
    vecs[20] = '{9'h18C, 9'h000, 9'h000, 1, 1'b1, 6'd0};

    reset      = 1'b1;
    char_addr  = 9'h000;
    char_valid = 1'b0;
    note_ready = 1'b1;
`ifdef NOTE_PARSER_ERRCNT_EN
    err_clear  = 1'b0;
`endif
    #2;
    check("reset char_ready", 9'(char_ready), 9'd1);
    check("reset note_valid", 9'(note_valid), 9'd0);
    check("reset note", 9'(note), 9'd0);
    check("reset err", 9'(err), 9'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      run_token(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].n, vecs[i].exp_err,
                vecs[i].exp_note, $sformatf("vec%0d", i));
    end

    // Back-pressure: note held, chars refused while stalled.
    note_ready = 1'b0;
    put_char(9'h188, "stall");
    put_char(9'h008, "stall");
    put_char(9'h100, "stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      char_valid = 1'b1;
      char_addr  = 9'h188;
      check($sformatf("stall%0d note_valid", k), 9'(note_valid), 9'd1);
      check($sformatf("stall%0d note", k), 9'(note), 9'd1);
      check($sformatf("stall%0d char_ready", k), 9'(char_ready), 9'd0);
      check($sformatf("stall%0d err", k), 9'(err), 9'd0);
    end
    @(negedge clk);
    char_valid = 1'b0;
    note_ready = 1'b1;
    check("stall release note_valid", 9'(note_valid), 9'd1);
    @(negedge clk);
    check("stall after char_ready", 9'(char_ready), 9'd1);
    check("stall after note_valid", 9'(note_valid), 9'd0);
    run_token(9'h100, 9'h100, 9'h100, 3, 1'b0, 6'd0, "post-stall rest");

    // Timeout fires exactly TO cycles after the last accept.
    put_char(9'h188, "timeout");
    @(negedge clk);
    char_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check($sformatf("timeout cycle%0d err", k), 9'(err), 9'(k == TO));
    end
    n_errs++;
    @(negedge clk);
    check("timeout err pulse width", 9'(err), 9'd0);
    check("timeout char_ready", 9'(char_ready), 9'd1);
    run_token(9'h188, 9'h008, 9'h100, 3, 1'b0, 6'd1, "after timeout");

    // TO-1 idle cycles inside a token must not expire.
    put_char(9'h188, "gap");
    @(negedge clk);
    char_valid = 1'b0;
    for (int k = 0; k < TO - 2; k++) begin
      @(negedge clk);
      check($sformatf("gap idle%0d err", k), 9'(err), 9'd0);
    end
    put_char(9'h008, "gap");
    put_char(9'h100, "gap");
    finish_token(1'b0, 6'd1, "gap");

`ifdef NOTE_PARSER_ERRCNT_EN
    check("err_count", 9'(err_count), 9'(n_errs));
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_count cleared", 9'(err_count), 9'd0);
`endif

    // Asynchronous reset mid-token discards the partial token.
    put_char(9'h1A8, "rst-token");
    put_char(9'h038, "rst-token");
    @(negedge clk);
    char_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst-token note_valid", 9'(note_valid), 9'd0);
    check("rst-token err", 9'(err), 9'd0);
    check("rst-token char_ready", 9'(char_ready), 9'd1);
    @(negedge clk);
    reset = 1'b0;
    run_token(9'h100, 9'h100, 9'h100, 3, 1'b0, 6'd0, "after rst-token");

    // Asynchronous reset in S_OUT loses the pending note.
    note_ready = 1'b0;
    put_char(9'h1A8, "rst-out");
    put_char(9'h038, "rst-out");
    put_char(9'h118, "rst-out");
    @(negedge clk);
    char_valid = 1'b0;
    check("rst-out pending note", 9'(note), 9'd60);
    #2 reset = 1'b1;
    #1;
    check("rst-out note_valid", 9'(note_valid), 9'd0);
    check("rst-out note", 9'(note), 9'd0);
    check("rst-out char_ready", 9'(char_ready), 9'd1);
    @(negedge clk);
    reset      = 1'b0;
    note_ready = 1'b1;
    run_token(9'h188, 9'h008, 9'h100, 3, 1'b0, 6'd1, "after rst-out");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/note_parser.md
Name: note_parser

Overview:
- Inverse of the note-to-character ROM: consumes a stream of 9-bit character-ROM addresses (octave digit, letter, symbol) and assembles them into a 6-bit note index.
- Sits between a character source (text entry or a character buffer) and the note player/sequencer.
- Uses valid/ready handshakes on both sides.
- Rejects malformed tokens with an error pulse.

Parameters:
- TIMEOUT, 0, inter-character timeout in clk cycles within a partial token; 0 disables the timeout.
- MAX_NOTE, 63, highest note index accepted; tokens decoding above this value are errors.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- char_addr  input  9  character ROM address of the incoming character
- char_valid  input  1  char_addr is valid this cycle
- char_ready  output  1  parser can accept a character this cycle
- note  output  6  decoded note index; 0 = rest
- note_valid  output  1  note is valid; held until accepted
- note_ready  input  1  downstream accepts note this cycle
- err  output  1  one-cycle pulse on a rejected token

Behaviour:
- Reset is asynchronous and active-high. Reset values: state S_NUM, note 0, note_valid 0, err 0, token registers 0, timeout counter 0.
- char_ready is combinational from state: 1 in S_NUM, S_LET and S_SYM; 0 in S_OUT. It is therefore 1 during and after reset.
- A character is accepted on a cycle with char_valid && char_ready.
- Character codes:
  - Digit n (1..6): 9'h180 + 8n, i.e. 9'h188..9'h1B0.
  - Letter A..G: 9'h008..9'h038 in steps of 8.
  - Space: 9'h100.
  - Hash: 9'h118.
  - Any other code in any slot is invalid.
- S_NUM: accepts a digit 1..6 or space; stores it and goes to S_LET. An invalid code is an error.
- S_LET:
  - After a digit: a letter is required; store it and go to S_SYM.
  - After a space: a space is required; go to S_SYM.
  - Otherwise error.
- S_SYM:
  - After a letter: space or hash is required.
  - After a space: space is required.
  - On a valid character, compute the note and go to S_OUT.
  - Otherwise error.
- Note arithmetic: note = 12*(octave-1) + off + 1.
  - off values: A=0, A#=1, B=2, C=3, C#=4, D=5, D#=6, E=7, F=8, F#=9, G=10, G#=11.
  - The rest token (three spaces) gives note 0.
  - Compute in 7 bits; the result is truncated to 6 bits only after the range check.
- Semantic errors, detected at S_SYM acceptance:
  - hash on B or E;
  - computed value > MAX_NOTE (covers octave 6 with letters C..G);
  - computed value > 63.
- S_OUT:
  - note and note_valid=1 are registered and appear the cycle after the third character is accepted (latency 1).
  - note and note_valid stay stable until note_ready=1.
  - On that cycle, go to S_NUM; note_valid=0 on the next cycle.
  - There is no same-cycle bypass, so the minimum token period is 4 cycles.
- Error handling:
  - err=1 for exactly one cycle, the cycle after the offending character is accepted (or after the timeout expires).
  - State returns to S_NUM and the partial token is discarded.
  - note_valid is never raised for an erroneous token.
- Timeout (TIMEOUT>0):
  - The counter counts cycles in S_LET or S_SYM with no character accepted.
  - It clears on every accepted character and on entry to S_NUM.
  - Reaching TIMEOUT triggers the error handling above.
  - The counter does not count in S_NUM or S_OUT.
- Reset mid-token or mid-S_OUT: everything returns to reset values immediately; the pending note is lost.

Optional Feature:
- Macro NOTE_PARSER_ERRCNT_EN.
- When defined: extra output port err_count (8 bits).
  - Increments on each err pulse and saturates at 8'hFF.
  - Reset value 0.
  - Clears synchronously while an extra input err_clear (1 bit) is high; clear wins over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
1. Send 9'h188, 9'h008, 9'h100 back-to-back, note_ready=1 → note_valid one cycle after the third accept with note=1; err stays 0.
2. Send 9'h1A8, 9'h038, 9'h118 → note=60. Then send 9'h1B0, 9'h010, 9'h100 → note=63. Then send 9'h1B0, 9'h018, 9'h100 → err pulse, no note_valid.
3. Send 9'h100, 9'h100, 9'h100 → note=0 with note_valid. Send 9'h100, 9'h008 → err after the second accept, state returns to S_NUM.
4. Send 9'h190, 9'h010, 9'h118 (B#) → err, no note_valid. Then send 9'h198, 9'h018, 9'h118 → note=29.
5. Complete a token with note_ready=0 for 5 cycles → note_valid and note stable and char_ready=0 throughout. Raise note_ready → char_ready=1 on the next cycle.
6. With TIMEOUT=10, send 9'h188 then idle → err exactly 10 cycles after the accept. Then send 9'h188, 9'h008, 9'h100 → note=1. Assert reset mid-token → all outputs return to reset values asynchronously.
